// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, serializer data bits, optional parity, stop bit.
// Optional parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TMO_TICKS = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TX_tick,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              ser_data,
    input  logic              ser_done,
    output logic [DATA_W-1:0] TX_DATA_O,
    output logic              ser_en,
    output logic              TX_OUT,
    output logic              busy,
    output logic              tmo_err
);

    localparam int unsigned CntW = $clog2(TMO_TICKS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              ser_en_q, ser_en_d;
    logic              tmo_q, tmo_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              latch;

`ifdef UART_TX_PARITY_EN
    logic par_bit_q, par_act_q;
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        busy_d   = busy_q;
        ser_en_d = ser_en_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        latch    = 1'b0;
        case (state_q)
            StIdle: begin
                if (DATA_VALID) begin
                    latch   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (TX_tick) begin
                    state_d  = StData;
                    ser_en_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            StData: begin
                if (TX_tick) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (ser_done) begin
                        ser_en_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d  = par_act_q ? StParity : StStop;
`else
                        state_d  = StStop;
`endif
                    end else if (cnt_q == CntW'(TMO_TICKS - 1)) begin
                        // Serializer never finished: abandon data, still send a stop bit.
                        ser_en_d = 1'b0;
                        tmo_d    = 1'b1;
                        state_d  = StStop;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (TX_tick) state_d = StStop;
            end
`endif
            StStop: begin
                if (TX_tick) begin
                    if (DATA_VALID) begin
                        latch   = 1'b1;
                        state_d = StStart;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (latch) data_d = P_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ser_en_q <= 1'b0;
            tmo_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            ser_en_q <= ser_en_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity mode is captured with the byte so mid-frame changes cannot corrupt the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_q <= 1'b0;
            par_act_q <= 1'b0;
        end else if (latch) begin
            par_act_q <= PAR_EN;
            par_bit_q <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        end
    end
`endif

    always_comb begin
        TX_OUT = 1'b1;
        case (state_q)
            StStart:  TX_OUT = 1'b0;
            StData:   TX_OUT = ser_data;
`ifdef UART_TX_PARITY_EN
            StParity: TX_OUT = par_bit_q;
`endif
            default:  TX_OUT = 1'b1;
        endcase
    end

    assign TX_DATA_O = data_q;
    assign busy      = busy_q;
    assign ser_en    = ser_en_q;
    assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: serializer model plus a queue of expected line bits.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
    localparam bit ParBuilt = 1'b1;
`else
    localparam bit ParBuilt = 1'b0;
`endif

    logic       CLK, RST, TX_tick, DATA_VALID, PAR_EN, PAR_TYP, ser_data, ser_done;
    logic [7:0] P_DATA, TX_DATA_O;
    logic       ser_en, TX_OUT, busy, tmo_err;

    int   checks = 0;
    int   errors = 0;
    int   tdiv   = 0;
    int   tmo_cnt = 0;
    logic no_done = 1'b0;
    logic [2:0] idx;
    logic exp_q[$];

    uart_tx_ctrl #(.DATA_W(8), .TMO_TICKS(10)) dut (
        .CLK(CLK), .RST(RST), .TX_tick(TX_tick), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
        .TX_DATA_O(TX_DATA_O), .ser_en(ser_en), .TX_OUT(TX_OUT), .busy(busy),
        .tmo_err(tmo_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Baud strobe: one CLK high every 4 CLKs, driven just after the rising edge.
    initial begin
        TX_tick = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            tdiv    = (tdiv == 3) ? 0 : tdiv + 1;
            TX_tick = (tdiv == 3);
        end
    end

    // LSB-first serializer: bit index advances on each tick while enabled.
    always @(posedge CLK or negedge RST) begin
        if (!RST)         idx <= 3'd0;
        else if (!ser_en) idx <= 3'd0;
        else if (TX_tick) idx <= idx + 3'd1;
    end
    assign ser_data = TX_DATA_O[idx];
    assign ser_done = !no_done && (idx == 3'd7);

    always @(posedge CLK) if (tmo_err) tmo_cnt <= tmo_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for the next active edge carrying a tick, then settle to the falling edge.
    task automatic next_tick();
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge CLK);
            if (TX_tick) seen = 1'b1;
        end
        if (!seen) check("tick_wait", 32'd0, 32'd1);
        @(negedge CLK);
    endtask

    // Present a byte while idle; returns at the falling edge after the accepting edge.
    task automatic accept(input logic [7:0] b, input bit pen, input bit ptyp,
                          input bit hold, input logic [7:0] nb);
        @(negedge CLK);
        P_DATA     = b;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        if (hold) begin
            P_DATA = nb;
        end else begin
            DATA_VALID = 1'b0;
            P_DATA     = ~b;
            PAR_EN     = ~pen;
            PAR_TYP    = ~ptyp;
        end
        @(negedge CLK);
        check("latched_byte", TX_DATA_O, b);
    endtask

    // Called at the falling edge after acceptance; ends once the stop bit is on the line.
    task automatic expect_frame(input logic [7:0] b, input bit pen, input bit ptyp,
                                input int poke);
        logic e;
        int   k = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (pen && ParBuilt) exp_q.push_back(ptyp ? ~(^b) : ^b);
        exp_q.push_back(1'b1);
        while (exp_q.size() > 0) begin
            if (k > 0) next_tick();
            e = exp_q.pop_front();
            check($sformatf("line_bit%0d", k), TX_OUT, e);
            check("busy_in_frame", busy, 1'b1);
            if (k == poke) begin
                P_DATA     = 8'hFF;
                DATA_VALID = 1'b1;
                @(posedge CLK);
                #1;
                DATA_VALID = 1'b0;
            end
            k++;
        end
    endtask

    task automatic finish_idle();
        next_tick();
        check("idle_line", TX_OUT, 1'b1);
        check("busy_fall", busy, 1'b0);
    endtask

    initial begin
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx_out", TX_OUT, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ser_en", ser_en, 1'b0);
        check("rst_tmo_err", tmo_err, 1'b0);
        check("rst_tx_data", TX_DATA_O, 8'h00);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Plain frame, then parity even/odd (10-bit frames when parity is not built).
        accept(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_frame(8'hA5, 1'b0, 1'b0, -1);
        finish_idle();
        accept(8'hA5, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_frame(8'hA5, 1'b1, 1'b0, -1);
        finish_idle();
        accept(8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
        expect_frame(8'hA5, 1'b1, 1'b1, -1);
        finish_idle();

        // Back-to-back: request held through the stop-exit tick.
        accept(8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3);
        expect_frame(8'h3C, 1'b0, 1'b0, -1);
        next_tick();
        DATA_VALID = 1'b0;
        expect_frame(8'hC3, 1'b0, 1'b0, -1);
        finish_idle();

        // Request during DATA is ignored.
        accept(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_frame(8'h00, 1'b0, 1'b0, 3);
        check("poke_byte_kept", TX_DATA_O, 8'h00);
        finish_idle();
        next_tick();
        check("poke_no_frame_line", TX_OUT, 1'b1);
        check("poke_no_frame_busy", busy, 1'b0);

        // Serializer never reports done.
        no_done = 1'b1;
        accept(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        check("tmo_start", TX_OUT, 1'b0);
        for (int i = 0; i < 10; i++) begin
            next_tick();
            check($sformatf("tmo_data%0d", i), TX_OUT, 1'b0);
            check("tmo_early", tmo_err, 1'b0);
        end
        next_tick();
        check("tmo_pulse", tmo_err, 1'b1);
        check("tmo_stop_bit", TX_OUT, 1'b1);
        check("tmo_ser_en", ser_en, 1'b0);
        @(negedge CLK);
        check("tmo_pulse_end", tmo_err, 1'b0);
        finish_idle();
        check("tmo_count", tmo_cnt, 1);
        no_done = 1'b0;

        // Asynchronous reset in the middle of DATA, then a clean frame.
        accept(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) next_tick();
        check("pre_rst_line", TX_OUT, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        check("arst_tx_out", TX_OUT, 1'b1);
        check("arst_busy", busy, 1'b0);
        check("arst_ser_en", ser_en, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        accept(8'h5A, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_frame(8'h5A, 1'b0, 1'b0, -1);
        finish_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
